// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux: round-robin or fixed-priority arbitration into one output
// register. Define STREAM_MUX_LAST_EN to add in_last/out_last and lock arbitration per packet.
module stream_mux_rr #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SELW = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
`ifdef STREAM_MUX_LAST_EN
   input  logic [NCH-1:0]       in_last,
   output logic                 out_last,
`endif
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_sel
);

   logic [SELW-1:0]  ptr, gnt_idx, ptr_nxt;
   logic             gnt_found, load_en, accept, ptr_adv;
   logic [WIDTH-1:0] chan_data [NCH];
   int unsigned      cand;

`ifdef STREAM_MUX_LAST_EN
   logic            lock;
   logic [SELW-1:0] lock_ch;
`endif

   for (genvar i = 0; i < NCH; i++) begin : g_unpack
      assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   assign load_en = !out_valid || out_ready;
   assign accept  = load_en && gnt_found;
   assign ptr_nxt = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);

`ifdef STREAM_MUX_LAST_EN
   // Mid-packet beats keep the pointer parked so the rotation resumes after the packet.
   assign ptr_adv = in_last[gnt_idx];
`else
   assign ptr_adv = 1'b1;
`endif

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
`ifdef STREAM_MUX_LAST_EN
      if (lock) begin
         gnt_found = in_valid[lock_ch];
         gnt_idx   = lock_ch;
      end else
`endif
      if (mode) begin
         for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (in_valid[SELW'(i)]) begin
               gnt_found = 1'b1;
               gnt_idx   = SELW'(i);
            end
         end
      end else begin
         for (int unsigned k = 0; k < NCH; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NCH) cand = cand - NCH;
            if (!gnt_found && in_valid[SELW'(cand)]) begin
               gnt_found = 1'b1;
               gnt_idx   = SELW'(cand);
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (load_en && rst_n && gnt_found) in_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         out_valid <= gnt_found;
         if (gnt_found) begin
            out_data <= chan_data[gnt_idx];
            out_sel  <= gnt_idx;
            if (ptr_adv) ptr <= ptr_nxt;
         end
      end
   end

`ifdef STREAM_MUX_LAST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_last <= 1'b0;
         lock     <= 1'b0;
         lock_ch  <= '0;
      end else if (accept) begin
         out_last <= in_last[gnt_idx];
         lock     <= !in_last[gnt_idx];
         lock_ch  <= gnt_idx;
      end
   end
`endif

endmodule
